// File: rtl/npc_gen.sv
// ---------------------------------------------------------------------------
// npc_gen -- next-PC generator for the MIPS fetch stage.
//
// Keeps a private copy of the current fetch address and presents the address
// the PC register loads on the next rising edge: sequential (pc+4), branch,
// jump (j/jal) or jump-register (jr/jalr) successor.
//
// Build option:
//   NPC_DELAY_SLOT_EN  defined   : MIPS branch delay slot. A taken transfer
//                                  first lets the slot address through, and
//                                  the target follows one cycle later.
//                                  link_addr = cur_pc + 8.
//                      undefined : the target is presented in the same cycle
//                                  as the transfer. link_addr = cur_pc + 4.
//
// Ports:
//   clk           in   system clock, rising edge
//   rst_npc       in   asynchronous active-high reset
//   stall         in   freeze fetch; all state holds
//   instr_valid   in   decode inputs describe the instruction at cur_pc
//   jmp_type[1:0] in   00 seq, 01 cond. branch, 10 j/jal, 11 jr/jalr
//   br_taken      in   branch condition (jmp_type = 01 only)
//   imm16[15:0]   in   signed branch offset in words
//   imm26[25:0]   in   jump index
//   rs_data[31:0] in   register target for jr/jalr
//   npc_out_addr  out  next fetch address
//   cur_pc        out  current fetch address
//   link_addr     out  return address for jal/jalr
//   redirect      out  high while a non-sequential target is presented
// ---------------------------------------------------------------------------
module npc_gen #(
   parameter logic [31:0] RESET_ADDR = 32'h0000_3000
) (
   input  logic        clk,
   input  logic        rst_npc,
   input  logic        stall,
   input  logic        instr_valid,
   input  logic [1:0]  jmp_type,
   input  logic        br_taken,
   input  logic [15:0] imm16,
   input  logic [25:0] imm26,
   input  logic [31:0] rs_data,
   output logic [31:0] npc_out_addr,
   output logic [31:0] cur_pc,
   output logic [31:0] link_addr,
   output logic        redirect
);

   logic [31:0] cur_pc_q, cur_pc_d;
   logic [31:0] pc4;
   logic [31:0] br_tgt, j_tgt, jr_tgt, tgt;
   logic        xfer;
   logic [31:0] npc_core;
   logic        redir_core;

   // ------------------------------------------------------------------
   // Successor addresses. All adds wrap modulo 2^32 by construction.
   // ------------------------------------------------------------------
   always_comb begin
      pc4    = cur_pc_q + 32'd4;
      br_tgt = pc4 + {{14{imm16[15]}}, imm16, 2'b00};
      j_tgt  = {pc4[31:28], imm26, 2'b00};
      // Masking keeps every rs_data bit referenced while forcing word alignment.
      jr_tgt = rs_data & 32'hFFFF_FFFC;
      xfer   = instr_valid && (jmp_type[1] || (jmp_type == 2'b01 && br_taken));
   end

   always_comb begin
      case (jmp_type)
         2'b10:   tgt = j_tgt;
         2'b11:   tgt = jr_tgt;
         default: tgt = br_tgt;
      endcase
   end

`ifdef NPC_DELAY_SLOT_EN
   typedef enum logic {
      SEQ   = 1'b0,
      DELAY = 1'b1
   } state_e;

   state_e      state_q, state_d;
   logic [31:0] tgt_reg_q, tgt_reg_d;

   // In DELAY the decode inputs belong to the delay-slot instruction and are
   // deliberately ignored, so a transfer in a slot never takes effect.
   always_comb begin
      // NOTE: every variable gets a default first so no path leaves it
      // unassigned; otherwise synthesis infers a latch.
      state_d    = state_q;
      tgt_reg_d  = tgt_reg_q;
      npc_core   = pc4;
      redir_core = 1'b0;
      if (stall) begin
         npc_core = cur_pc_q;
      end else if (state_q == DELAY) begin
         npc_core   = tgt_reg_q;
         redir_core = 1'b1;
         state_d    = SEQ;
      end else if (xfer) begin
         tgt_reg_d = tgt;
         state_d   = DELAY;
      end
   end

   always_ff @(posedge clk or posedge rst_npc) begin
      if (rst_npc) begin
         state_q   <= SEQ;
         tgt_reg_q <= 32'h0;
      end else begin
         state_q   <= state_d;
         tgt_reg_q <= tgt_reg_d;
      end
   end

   assign link_addr = cur_pc_q + 32'd8;
`else
   always_comb begin
      npc_core   = pc4;
      redir_core = 1'b0;
      if (stall) begin
         npc_core = cur_pc_q;
      end else if (xfer) begin
         npc_core   = tgt;
         redir_core = 1'b1;
      end
   end

   assign link_addr = pc4;
`endif

   // A stalled cycle presents cur_pc, so loading npc_core unconditionally
   // also implements the hold.
   assign cur_pc_d = npc_core;

   always_ff @(posedge clk or posedge rst_npc) begin
      if (rst_npc) begin
         cur_pc_q <= RESET_ADDR;
      end else begin
         // NOTE: sequential state uses non-blocking assignment so every flop
         // samples pre-edge values regardless of statement order.
         cur_pc_q <= cur_pc_d;
      end
   end

   // Reset overrides the combinational outputs immediately, even mid-DELAY.
   assign npc_out_addr = rst_npc ? RESET_ADDR : npc_core;
   assign redirect     = !rst_npc && redir_core;
   assign cur_pc       = cur_pc_q;

endmodule

// File: tb/tb_npc_gen.sv
// ---------------------------------------------------------------------------
// tb_npc_gen -- self-checking bench for npc_gen. Works in either build
// (NPC_DELAY_SLOT_EN defined or not): a behavioural fetch model pushes the
// expected outputs for each driven cycle to a scoreboard queue, and each
// scenario task pops and compares at the falling edge.
// ---------------------------------------------------------------------------
module tb_npc_gen;

   localparam logic [31:0] RST_A = 32'h0000_3000;

   typedef struct {
      logic        st;
      logic        iv;
      logic [1:0]  jt;
      logic        bt;
      logic [15:0] i16;
      logic [25:0] i26;
      logic [31:0] rs;
   } stim_t;

   typedef struct packed {
      logic [31:0] npc;
      logic [31:0] pc;
      logic [31:0] link;
      logic        redir;
   } exp_t;

   logic        clk;
   logic        rst_npc;
   logic        stall;
   logic        instr_valid;
   logic [1:0]  jmp_type;
   logic        br_taken;
   logic [15:0] imm16;
   logic [25:0] imm26;
   logic [31:0] rs_data;
   logic [31:0] npc_out_addr;
   logic [31:0] cur_pc;
   logic [31:0] link_addr;
   logic        redirect;

   int   n_checks = 0;
   int   n_fail   = 0;
   exp_t sb[$];

   // Reference fetch model state.
   logic [31:0] m_pc;
`ifdef NPC_DELAY_SLOT_EN
   logic        m_dly;
   logic [31:0] m_tgt;
`endif

   npc_gen dut (
      .clk          (clk),
      .rst_npc      (rst_npc),
      .stall        (stall),
      .instr_valid  (instr_valid),
      .jmp_type     (jmp_type),
      .br_taken     (br_taken),
      .imm16        (imm16),
      .imm26        (imm26),
      .rs_data      (rs_data),
      .npc_out_addr (npc_out_addr),
      .cur_pc       (cur_pc),
      .link_addr    (link_addr),
      .redirect     (redirect)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   function automatic stim_t mk(input logic st, input logic iv, input logic [1:0] jt,
                                input logic bt, input logic [15:0] i16,
                                input logic [25:0] i26, input logic [31:0] rs);
      stim_t s;
      s.st = st; s.iv = iv; s.jt = jt; s.bt = bt;
      s.i16 = i16; s.i26 = i26; s.rs = rs;
      return s;
   endfunction

   function automatic stim_t seq();
      return mk(1'b0, 1'b0, 2'b00, 1'b0, 16'h0, 26'h0, 32'h0);
   endfunction

   task automatic model_reset();
      m_pc = RST_A;
`ifdef NPC_DELAY_SLOT_EN
      m_dly = 1'b0;
      m_tgt = 32'h0;
`endif
   endtask

   // Drives one cycle of decode inputs and pushes the expected outputs.
   task automatic drive(input stim_t s);
      exp_t        e;
      logic [31:0] pc4, tgt;
      logic        take;
      stall       = s.st;
      instr_valid = s.iv;
      jmp_type    = s.jt;
      br_taken    = s.bt;
      imm16       = s.i16;
      imm26       = s.i26;
      rs_data     = s.rs;

      pc4  = m_pc + 32'd4;
      take = s.iv && ((s.jt == 2'b10) || (s.jt == 2'b11) || (s.jt == 2'b01 && s.bt));
      if (s.jt == 2'b01)      tgt = pc4 + 32'($signed(s.i16) * 4);
      else if (s.jt == 2'b10) tgt = {pc4[31:28], s.i26, 2'b00};
      else                    tgt = {s.rs[31:2], 2'b00};

      e.pc    = m_pc;
      e.redir = 1'b0;
`ifdef NPC_DELAY_SLOT_EN
      e.link = m_pc + 32'd8;
      if (s.st) begin
         e.npc = m_pc;
      end else if (m_dly) begin
         e.npc   = m_tgt;
         e.redir = 1'b1;
         m_dly   = 1'b0;
      end else begin
         e.npc = pc4;
         if (take) begin
            m_tgt = tgt;
            m_dly = 1'b1;
         end
      end
`else
      e.link = m_pc + 32'd4;
      if (s.st) begin
         e.npc = m_pc;
      end else if (take) begin
         e.npc   = tgt;
         e.redir = 1'b1;
      end else begin
         e.npc = pc4;
      end
`endif
      m_pc = e.npc;
      sb.push_back(e);
   endtask

   task automatic apply_reset();
      rst_npc = 1'b1;
      drive(seq());
      sb.delete();
      @(posedge clk);
      #1;
      rst_npc = 1'b0;
      model_reset();
   endtask

   // ------------------------------------------------------------------
   task automatic test_reset();
      stim_t s[$];
      exp_t  e, o;
      rst_npc = 1'b1;
      drive(seq());
      sb.delete();
      @(negedge clk);
      n_checks++;
      if (npc_out_addr !== RST_A) begin
         n_fail++;
         $display("FAIL reset_npc: got %h expected %h", npc_out_addr, RST_A);
      end
      n_checks++;
      if (redirect !== 1'b0) begin
         n_fail++;
         $display("FAIL reset_redirect: got %b expected 0", redirect);
      end
      n_checks++;
      if (cur_pc !== RST_A) begin
         n_fail++;
         $display("FAIL reset_cur_pc: got %h expected %h", cur_pc, RST_A);
      end
      @(posedge clk);
      #1;
      rst_npc = 1'b0;
      model_reset();
      for (int i = 0; i < 3; i++) s.push_back(seq());
      foreach (s[i]) begin
         drive(s[i]);
         @(negedge clk);
         e = sb.pop_front();
         o = {npc_out_addr, cur_pc, link_addr, redirect};
         n_checks++;
         if (o !== e) begin
            n_fail++;
            $display("FAIL reset_seq[%0d]: got npc=%h pc=%h link=%h redir=%b expected npc=%h pc=%h link=%h redir=%b",
                     i, o.npc, o.pc, o.link, o.redir, e.npc, e.pc, e.link, e.redir);
         end
         @(posedge clk);
         #1;
      end
   endtask

   task automatic test_branch();
      stim_t s[$];
      exp_t  e, o;
      apply_reset();
      s.push_back(seq());                                                   // 3000
      s.push_back(seq());                                                   // 3004
      s.push_back(mk(1'b0, 1'b1, 2'b01, 1'b1, 16'h0004, 26'h0, 32'h0));     // 3008 taken
      s.push_back(mk(1'b0, 1'b1, 2'b10, 1'b0, 16'h0, 26'h0000040, 32'h0));  // slot: j ignored
      s.push_back(seq());
      s.push_back(mk(1'b0, 1'b0, 2'b10, 1'b0, 16'h0, 26'h0000040, 32'h0));  // invalid j
      foreach (s[i]) begin
         drive(s[i]);
         @(negedge clk);
         e = sb.pop_front();
         o = {npc_out_addr, cur_pc, link_addr, redirect};
         n_checks++;
         if (o !== e) begin
            n_fail++;
            $display("FAIL branch[%0d]: got npc=%h pc=%h link=%h redir=%b expected npc=%h pc=%h link=%h redir=%b",
                     i, o.npc, o.pc, o.link, o.redir, e.npc, e.pc, e.link, e.redir);
         end
         @(posedge clk);
         #1;
      end
   endtask

   task automatic test_backward();
      stim_t s[$];
      exp_t  e, o;
      apply_reset();
      for (int i = 0; i < 4; i++) s.push_back(seq());                       // to 3010
      s.push_back(mk(1'b0, 1'b1, 2'b01, 1'b1, 16'hFFFF, 26'h0, 32'h0));     // backward taken
      s.push_back(seq());
      s.push_back(mk(1'b0, 1'b1, 2'b01, 1'b0, 16'hFFFF, 26'h0, 32'h0));     // not taken
      s.push_back(seq());
      foreach (s[i]) begin
         drive(s[i]);
         @(negedge clk);
         e = sb.pop_front();
         o = {npc_out_addr, cur_pc, link_addr, redirect};
         n_checks++;
         if (o !== e) begin
            n_fail++;
            $display("FAIL backward[%0d]: got npc=%h pc=%h link=%h redir=%b expected npc=%h pc=%h link=%h redir=%b",
                     i, o.npc, o.pc, o.link, o.redir, e.npc, e.pc, e.link, e.redir);
         end
         @(posedge clk);
         #1;
      end
   endtask

   task automatic test_jr_jal();
      stim_t s[$];
      exp_t  e, o;
      apply_reset();
      for (int i = 0; i < 8; i++) s.push_back(seq());                       // to 3020
      s.push_back(mk(1'b0, 1'b1, 2'b11, 1'b0, 16'h0, 26'h0, 32'h0000_3103)); // jr
      s.push_back(seq());
      s.push_back(mk(1'b0, 1'b1, 2'b10, 1'b0, 16'h0, 26'h0000C40, 32'h0));  // jal at 3100
      s.push_back(seq());
      s.push_back(seq());
      foreach (s[i]) begin
         drive(s[i]);
         @(negedge clk);
         e = sb.pop_front();
         o = {npc_out_addr, cur_pc, link_addr, redirect};
         n_checks++;
         if (o !== e) begin
            n_fail++;
            $display("FAIL jr_jal[%0d]: got npc=%h pc=%h link=%h redir=%b expected npc=%h pc=%h link=%h redir=%b",
                     i, o.npc, o.pc, o.link, o.redir, e.npc, e.pc, e.link, e.redir);
         end
         @(posedge clk);
         #1;
      end
   endtask

   task automatic test_stall_reset();
      stim_t s[$];
      exp_t  e, o;
      stim_t br;
      apply_reset();
      br = mk(1'b0, 1'b1, 2'b01, 1'b1, 16'h0004, 26'h0, 32'h0);
      s.push_back(seq());
      s.push_back(seq());
      s.push_back(mk(1'b1, 1'b1, 2'b01, 1'b1, 16'h0010, 26'h0, 32'h0));     // stalled transfer
      s.push_back(seq());                                                   // must not redirect
      s.push_back(br);                                                      // enter DELAY
      for (int i = 0; i < 3; i++)
         s.push_back(mk(1'b1, 1'b1, 2'b11, 1'b0, 16'h0, 26'h0, 32'h0000_5000));
      s.push_back(seq());                                                   // target released
      s.push_back(br);                                                      // DELAY again
      foreach (s[i]) begin
         drive(s[i]);
         @(negedge clk);
         e = sb.pop_front();
         o = {npc_out_addr, cur_pc, link_addr, redirect};
         n_checks++;
         if (o !== e) begin
            n_fail++;
            $display("FAIL stall[%0d]: got npc=%h pc=%h link=%h redir=%b expected npc=%h pc=%h link=%h redir=%b",
                     i, o.npc, o.pc, o.link, o.redir, e.npc, e.pc, e.link, e.redir);
         end
         @(posedge clk);
         #1;
      end
      // Reset while a target is pending.
      rst_npc = 1'b1;
      stall   = 1'b0;
      @(negedge clk);
      n_checks++;
      if (npc_out_addr !== RST_A || redirect !== 1'b0 || cur_pc !== RST_A) begin
         n_fail++;
         $display("FAIL mid_delay_reset: got npc=%h redir=%b pc=%h expected npc=%h redir=0 pc=%h",
                  npc_out_addr, redirect, cur_pc, RST_A, RST_A);
      end
      @(posedge clk);
      #1;
      rst_npc = 1'b0;
      model_reset();
      s.delete();
      for (int i = 0; i < 3; i++) s.push_back(seq());
      foreach (s[i]) begin
         drive(s[i]);
         @(negedge clk);
         e = sb.pop_front();
         o = {npc_out_addr, cur_pc, link_addr, redirect};
         n_checks++;
         if (o !== e) begin
            n_fail++;
            $display("FAIL post_reset[%0d]: got npc=%h pc=%h link=%h redir=%b expected npc=%h pc=%h link=%h redir=%b",
                     i, o.npc, o.pc, o.link, o.redir, e.npc, e.pc, e.link, e.redir);
         end
         @(posedge clk);
         #1;
      end
   endtask

   task automatic test_wrap_back_to_back();
      stim_t s[$];
      exp_t  e, o;
      apply_reset();
      s.push_back(seq());
      s.push_back(seq());
      s.push_back(mk(1'b0, 1'b1, 2'b11, 1'b0, 16'h0, 26'h0, 32'hFFFF_FFFF)); // jr -> FFFFFFFC
      s.push_back(mk(1'b0, 1'b1, 2'b01, 1'b1, 16'h0100, 26'h0, 32'h0));     // slot branch ignored
      s.push_back(seq());                                                   // wrap to 0
      s.push_back(mk(1'b0, 1'b1, 2'b01, 1'b1, 16'h7FFF, 26'h0, 32'h0));     // max forward
      s.push_back(seq());
      s.push_back(mk(1'b0, 1'b1, 2'b10, 1'b0, 16'h0, 26'h0, 32'h0));        // back-to-back jal
      s.push_back(seq());
      s.push_back(seq());
      foreach (s[i]) begin
         drive(s[i]);
         @(negedge clk);
         e = sb.pop_front();
         o = {npc_out_addr, cur_pc, link_addr, redirect};
         n_checks++;
         if (o !== e) begin
            n_fail++;
            $display("FAIL wrap[%0d]: got npc=%h pc=%h link=%h redir=%b expected npc=%h pc=%h link=%h redir=%b",
                     i, o.npc, o.pc, o.link, o.redir, e.npc, e.pc, e.link, e.redir);
         end
         @(posedge clk);
         #1;
      end
      n_checks++;
      if (sb.size() != 0) begin
         n_fail++;
         $display("FAIL scoreboard_drain: got %0d entries left expected 0", sb.size());
      end
   endtask

   initial begin
      rst_npc     = 1'b1;
      stall       = 1'b0;
      instr_valid = 1'b0;
      jmp_type    = 2'b00;
      br_taken    = 1'b0;
      imm16       = 16'h0;
      imm26       = 26'h0;
      rs_data     = 32'h0;
      model_reset();
      #1;
      test_reset();
      test_branch();
      test_backward();
      test_jr_jal();
      test_stall_reset();
      test_wrap_back_to_back();
      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule
